sad_row_scheduler: RTL and testbench

SAD_ROW_SCHEDULER -- requirements
Module: sad_row_scheduler

---
 rtl/sad_row_scheduler_if.sv | 29 ++
 rtl/sad_row_scheduler.sv | 167 ++++++++++++++++
 tb/tb_sad_row_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_row_scheduler_if.sv
// rtl/sad_row_scheduler_if.sv - control, row stream and result bundle for the SAD row scheduler
interface sad_row_scheduler_if #(
    parameter int PIX_W = 8,
    parameter int LANES = 8,
    parameter int SAD_W = 16
);
    logic                   start;
    logic [4:0]             rows;
    logic                   abort;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] cur_pix;
    logic [LANES*PIX_W-1:0] ref_pix;
    logic [SAD_W-1:0]       sad;
    logic                   sad_valid;
    logic                   sad_ready;
    logic                   busy;
    logic                   err;

    modport master (
        output start, rows, abort, in_valid, cur_pix, ref_pix, sad_ready,
        input  in_ready, sad, sad_valid, busy, err
    );

    modport slave (
        input  start, rows, abort, in_valid, cur_pix, ref_pix, sad_ready,
        output in_ready, sad, sad_valid, busy, err
    );
endinterface

// File: rtl/sad_row_scheduler.sv
// rtl/sad_row_scheduler.sv - block SAD accumulator: 3-stage row pipeline under an IDLE/RUN/DRAIN/DONE scheduler
module sad_row_scheduler #(
    parameter int PIX_W = 8,
    parameter int LANES = 8,
    parameter int SAD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sad_row_scheduler_if.slave   bus
);
    localparam int ROW_W = PIX_W + 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [4:0]         rows_lat;
    logic [4:0]         row_cnt;
    logic               drain_cnt;
    logic               rows_ok;
    logic               start_ok;
    logic               accept;
    logic               last_accept;
    logic               clear;
    logic               in_ready_c;
    logic               busy_c;
    logic               sad_valid_c;
    logic [SAD_W-1:0]   sad_c;
    logic               err_q;

    logic [PIX_W-1:0]   diff_d [LANES];
    logic [PIX_W-1:0]   diff_q [LANES];
    logic               s1_valid;
    logic [ROW_W-1:0]   row_sum;
    logic [ROW_W-1:0]   row_sum_q;
    logic               s2_valid;
    logic [SAD_W-1:0]   acc;

    assign rows_ok     = (bus.rows != 5'd0) && (bus.rows <= 5'd16);
    assign start_ok    = (state == IDLE) && bus.start && rows_ok;
    // abort wins over a row offered in the same cycle
    assign accept      = (state == RUN) && bus.in_valid && !bus.abort;
    assign last_accept = accept && ((row_cnt + 5'd1) == rows_lat);
    assign clear       = (state != IDLE) && bus.abort;

    // absolute difference per lane, unsigned
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PIX_W-1:0] c, r;
        assign c = bus.cur_pix[i*PIX_W +: PIX_W];
        assign r = bus.ref_pix[i*PIX_W +: PIX_W];
        assign diff_d[i] = (c >= r) ? (c - r) : (r - c);
    end

    // one 3:2 carry-save cell across every bit column; carries fit because the true sum fits ROW_W
    function automatic logic [2*ROW_W-1:0] csa(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b,
                                               input logic [ROW_W-1:0] c);
        logic [ROW_W-1:0] s, cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    // 8:2 compression of the registered differences, then a single carry-propagate add
    always_comb begin
        logic [ROW_W-1:0] op [8];
        logic [2*ROW_W-1:0] l1a, l1b, l2a, l2b, l3, l4;
        for (int i = 0; i < 8; i++) begin
            op[i] = ROW_W'(diff_q[i]);
        end
        l1a = csa(op[0], op[1], op[2]);
        l1b = csa(op[3], op[4], op[5]);
        l2a = csa(l1a[ROW_W-1:0], l1a[2*ROW_W-1:ROW_W], l1b[ROW_W-1:0]);
        l2b = csa(l1b[2*ROW_W-1:ROW_W], op[6], op[7]);
        l3  = csa(l2a[ROW_W-1:0], l2a[2*ROW_W-1:ROW_W], l2b[ROW_W-1:0]);
        l4  = csa(l3[ROW_W-1:0], l3[2*ROW_W-1:ROW_W], l2b[2*ROW_W-1:ROW_W]);
        row_sum = l4[ROW_W-1:0] + l4[2*ROW_W-1:ROW_W];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next-state and status outputs
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        busy_c      = 1'b1;
        sad_valid_c = 1'b0;
        sad_c       = '0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (start_ok) state_next = RUN;
            end
            RUN: begin
                in_ready_c = 1'b1;
                if (bus.abort)        state_next = IDLE;
                else if (last_accept) state_next = DRAIN;
            end
            DRAIN: begin
                if (bus.abort)      state_next = IDLE;
                else if (drain_cnt) state_next = DONE;
            end
            DONE: begin
                sad_valid_c = 1'b1;
                sad_c       = acc;
                if (bus.abort || bus.sad_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.sad_valid = sad_valid_c;
    assign bus.sad       = sad_c;
    assign bus.err       = err_q;

    // block bookkeeping: latched row count, accepted rows, drain timer, illegal-start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_lat  <= '0;
            row_cnt   <= '0;
            drain_cnt <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q     <= (state == IDLE) && bus.start && !rows_ok;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (start_ok) rows_lat <= bus.rows;
            if (clear || start_ok) row_cnt <= '0;
            else if (accept)       row_cnt <= row_cnt + 5'd1;
        end
    end

    // stage 1: lane differences
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) diff_q[i] <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                for (int i = 0; i < LANES; i++) diff_q[i] <= diff_d[i];
            end
        end
    end

    // stage 2: row sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            row_sum_q <= '0;
        end else begin
            s2_valid <= s1_valid && !clear;
            if (s1_valid) row_sum_q <= row_sum;
        end
    end

    // stage 3: wrapping accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                acc <= '0;
        else if (clear || start_ok) acc <= '0;
        else if (s2_valid)         acc <= acc + SAD_W'(row_sum_q);
    end
endmodule

// File: tb/tb_sad_row_scheduler.sv
// tb/tb_sad_row_scheduler.sv - scoreboard bench for sad_row_scheduler
module tb_sad_row_scheduler;
    logic clk;
    logic rst_n;

    sad_row_scheduler_if bus();

    sad_row_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] fill(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [4:0] r);
        bus.rows  = r;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_row(input logic [63:0] c, input logic [63:0] r);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.cur_pix  = c;
        bus.ref_pix  = r;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("row_accepted", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check(name, bus.busy, 0);
    endtask

    // scoreboard monitor: compare every delivered result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.sad_valid && bus.sad_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sad_value", bus.sad, mon_exp);
            end
        end
    end

    initial begin
        int lat;
        int n;
        int accepts;
        logic [63:0] c3, r3;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.rows     = '0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.cur_pix  = '0;
        bus.ref_pix  = '0;
        bus.sad_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_sad_valid", bus.sad_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_sad", bus.sad, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single row: 8 lanes of |10-3|
        exp_q.push_back(16'd56);
        start_block(5'd1);
        send_row(fill(8'd10), fill(8'd3));
        lat = 1;
        @(negedge clk);
        while (!bus.sad_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check("latency_rows1", lat, 3);
        tick();
        wait_idle("idle_t1");

        // 16 full-scale rows; rows input changed mid-block must be ignored
        exp_q.push_back(16'd32640);
        start_block(5'd16);
        bus.rows     = 5'd2;
        bus.in_valid = 1'b1;
        bus.cur_pix  = fill(8'd255);
        bus.ref_pix  = fill(8'd0);
        accepts = 0;
        n = 0;
        while (accepts < 16 && n < 40) begin
            @(negedge clk);
            if (bus.in_ready) accepts++;
            n++;
            tick();
        end
        check("accepts_16", accepts, 16);
        @(negedge clk);
        check("in_ready_dropped", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        tick();
        wait_idle("idle_t2");

        // alternating bubbles; lane i diff = i, cur<ref on odd lanes; bubble data is large garbage
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                c3[i*8 +: 8] = 8'(50 + i);
                r3[i*8 +: 8] = 8'd50;
            end else begin
                c3[i*8 +: 8] = 8'd50;
                r3[i*8 +: 8] = 8'(50 + i);
            end
        end
        exp_q.push_back(16'd112);
        start_block(5'd4);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.cur_pix  = (k % 2 == 0) ? c3 : fill(8'd255);
            bus.ref_pix  = (k % 2 == 0) ? r3 : fill(8'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_idle("idle_t3");

        // back-pressure in DONE, then handshake with a simultaneous start
        bus.sad_ready = 1'b0;
        exp_q.push_back(16'd16);
        start_block(5'd1);
        send_row(fill(8'd12), fill(8'd10));
        n = 0;
        while (!bus.sad_valid && n < 20) begin
            tick();
            n++;
        end
        check("t4_valid_rise", bus.sad_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_valid_held", bus.sad_valid, 1);
            check("t4_sad_held", bus.sad, 16);
            tick();
        end
        bus.sad_ready = 1'b1;
        bus.rows      = 5'd1;
        bus.start     = 1'b1;
        @(negedge clk);
        tick();
        bus.start = 1'b0;
        check("t4_idle_after_hs", bus.busy, 0);
        tick();
        check("t4_start_ignored", bus.busy, 0);
        check("t4_no_ready", bus.in_ready, 0);

        // illegal row counts
        start_block(5'd0);
        check("err_rows0", bus.err, 1);
        check("busy_rows0", bus.busy, 0);
        tick();
        check("err_rows0_clear", bus.err, 0);
        start_block(5'd20);
        check("err_rows20", bus.err, 1);
        check("busy_rows20", bus.busy, 0);
        tick();
        check("err_rows20_clear", bus.err, 0);
        check("busy_after_err", bus.busy, 0);

        // abort during row 3 of 8
        start_block(5'd8);
        send_row(fill(8'd5), fill(8'd4));
        send_row(fill(8'd5), fill(8'd4));
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_idle", bus.busy, 0);
        check("abort_no_ready", bus.in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_result", bus.sad_valid, 0);
            tick();
        end

        // reset pulse while draining
        start_block(5'd2);
        send_row(fill(8'd200), fill(8'd0));
        send_row(fill(8'd200), fill(8'd0));
        check("drain_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_valid", bus.sad_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_result", bus.sad_valid, 0);
            tick();
        end

        // clean block after abort and reset
        exp_q.push_back(16'd8);
        start_block(5'd1);
        send_row(fill(8'd9), fill(8'd8));
        wait_idle("idle_t6");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
